fp32_mul_arbiter: RTL and testbench
===================================

# fp32_mul_arbiter

Round-robin arbiter that shares one pipelined `fp32_mul` instance among `NREQ` requesters (integer/FP issue ports, divider/sqrt microcode, etc.). It accepts one multiply per cycle over per-requester valid/ready handshakes and registers the winning operands and rounding mode into the multiplier. It tracks in-flight operations with a tag shift register matched to the multiplier latency, and routes each result plus its `nv/of/uf/nx` flags back to the originating requester. It sits between the FP issue logic and `fp32_mul`, and owns the only connection to the multiplier's inputs.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..8.
- `LATENCY`, 3: `fp32_mul` cycles from operand input to registered `result`/flags; must equal the instantiated multiplier's depth.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: requester i has an operation.
- `req_ready` out NREQ: grant; transfer when `req_valid[i] & req_ready[i]`.
- `req_a` in 32*NREQ: operand a, slice i = bits [32i+31:32i].
- `req_b` in 32*NREQ: operand b, same packing.
- `req_rm` in 3*NREQ: rounding mode (`RM_RNE/RTZ/RDN/RUP/RMM`), slice i = [3i+2:3i].
- `mul_a`, `mul_b` out 32: registered operands to `fp32_mul`.
- `mul_rm` out 3: registered rounding mode to `fp32_mul`.
- `mul_result` in 32: `fp32_mul.result`.
- `mul_nv`, `mul_of`, `mul_uf`, `mul_nx` in 1 each: `fp32_mul` flags.
- `resp_valid` out NREQ: one-hot, one-cycle pulse; response for requester i.
- `resp_result` out 32: result, shared by all requesters, qualified by `resp_valid`.
- `resp_flags` out 4: {nv,of,uf,nx}, shared, qualified by `resp_valid`.
- `busy` out 1: any operation issued but not yet responded.
- `sticky_flags` out 4*NREQ: accumulated {nv,of,uf,nx} per requester (see Configuration).
- `flag_clr` in NREQ: clear `sticky_flags` slice i.

## Operation
- Arbitration: combinational round-robin over `req_valid`. Priority starts at pointer `ptr`; the first valid requester at or after `ptr` (mod NREQ) is granted. At most one `req_ready` is high per cycle, and `req_ready` is 0 for every non-valid requester.
- On handshake with requester g: `ptr <= (g+1) mod NREQ`. Without a handshake, `ptr` holds.
- Issue register: on handshake, `mul_a/mul_b/mul_rm <= req_a/b/rm[g]`, `iss_v <= 1`, `iss_id <= g`. Without a handshake, operands are forced to 0, `mul_rm <= 0`, and `iss_v <= 0`.
- Tag pipe: `LATENCY` entries of {v, id}. Entry 0 loads {`iss_v`,`iss_id`}, and entries shift every cycle unconditionally. The multiplier cannot stall, so the arbiter never stalls.
- Response: when the last tag entry has v=1, `resp_valid[id]` = 1, `resp_result` = `mul_result`, and `resp_flags` = mul flags. Otherwise `resp_valid` = 0 and `resp_result`/`resp_flags` = 0.
- Responses have no backpressure. Requesters must accept the pulse.
- Order: responses return in issue order. Each requester sees its own results in its own handshake order.
- `busy` = `iss_v` | OR of all tag v bits.
- Reset values: `ptr`=0, `iss_v`=0, all tag v=0, `mul_a`=`mul_b`=0, `mul_rm`=0, `resp_valid`=0, `resp_result`=0, `resp_flags`=0, `busy`=0, `sticky_flags`=0. `req_ready` is combinational and 0 when all `req_valid` are 0.
- `rst` mid-flight: all in-flight tags are dropped and no `resp_valid` is ever produced for them. Stale `fp32_mul` outputs are ignored because v=0. `req_ready` is forced to 0 while `rst` = 1.

## Timing
- Handshake in cycle T → `mul_a/b/rm` valid in T+1 → `resp_valid` in T+1+LATENCY. Total latency is LATENCY+1 (4 by default).
- Throughput: 1 op/cycle aggregate, with back-to-back handshakes allowed. With all NREQ requesters continuously valid, each is granted once every NREQ cycles.
- `req_a/b/rm` are sampled only in the handshake cycle. A requester may change them freely afterward.

## Configuration
- `FP_MUL_ARB_STICKY_EN` defined: on `resp_valid[i]`, `sticky_flags[i] <= sticky_flags[i] | resp_flags`. `flag_clr[i]` clears slice i. If `flag_clr[i]` and `resp_valid[i]` occur in the same cycle, the result is `resp_flags`: clear old, keep new.
- Undefined: `sticky_flags` is tied to 0, `flag_clr` is ignored, and no accumulation registers exist. The port list is unchanged.

## Test plan
- Single op: req0 a=0x41200000, b=0x41200000, rm=RNE at cycle T → `resp_valid`=2'b01 at T+4, `resp_result`=0x42C80000, `resp_flags`=0000. `busy` is high T+1..T+4.
- Contention: req0 and req1 are both valid with a=0x40000000, b=0x40400000 (req0) and a=0x3F800000, b=0xC0000000 (req1) after reset. req0 is granted first, then req1. Expect `resp_valid`=01 with 0x40C00000, then 10 with 0xC0000000 on consecutive cycles.
- Fairness: both requesters held valid for 8 cycles → grants alternate 0,1,0,1… with exactly 4 each, and 8 consecutive `resp_valid` pulses in the same order.
- Exceptions: req1 sends 0x7F7FFFFF×0x7F7FFFFF RNE → 0x7F800000, flags {0,1,0,1}. req0 sends 0x7F800000×0x00000000 → 0x7FC00000, flags {1,0,0,0}. With `FP_MUL_ARB_STICKY_EN`, `sticky_flags` = {0101 for req1, 1000 for req0}. `flag_clr[1]` in the cycle of a new req1 response with nx only → slice 1 = 0001.
- Reset mid-flight: issue 3 ops on consecutive cycles and assert `rst` for one cycle two cycles after the first handshake → no `resp_valid` for any of them. `busy`=0 and `ptr`=0 after reset. The next op completes normally in 4 cycles.
- Idle: no `req_valid` for 10 cycles → `mul_a`=`mul_b`=0, `resp_valid`=0, and `busy`=0 throughout.

Source files
------------

// File: rtl/fp32_mul_arbiter.sv
// rtl/fp32_mul_arbiter.sv - round-robin arbiter sharing one pipelined fp32_mul among NREQ requesters
//
// Purpose:
//   Grants at most one requester per cycle (round-robin from ptr), registers the
//   winning operands/rounding mode into fp32_mul, tracks in-flight operations with
//   a LATENCY-deep tag pipe and routes each result and its flags back to the
//   requester that issued it. Never stalls: the multiplier cannot stall either.
//
// Optional feature:
//   FP_MUL_ARB_STICKY_EN - when defined, per-requester sticky {nv,of,uf,nx}
//   accumulators exist and flag_clr clears them; when undefined sticky_flags is 0.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready [NREQ]  per-requester handshake (ready is the grant)
//   req_a, req_b [32*NREQ]      packed operands, slice i = [32i+31:32i]
//   req_rm [3*NREQ]             packed rounding modes, slice i = [3i+2:3i]
//   mul_a, mul_b, mul_rm        registered operands/rounding mode to fp32_mul
//   mul_result, mul_nv/of/uf/nx fp32_mul outputs, valid LATENCY cycles after input
//   resp_valid [NREQ]           one-hot response pulse
//   resp_result, resp_flags     shared response data {nv,of,uf,nx}
//   busy                        any operation issued and not yet responded
//   sticky_flags [4*NREQ]       accumulated flags per requester
//   flag_clr [NREQ]             clears sticky_flags slice i

module fp32_mul_arbiter #(
    parameter int NREQ    = 2,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0]    req_rm,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic [2:0]           mul_rm,
    input  logic [31:0]          mul_result,
    input  logic                 mul_nv,
    input  logic                 mul_of,
    input  logic                 mul_uf,
    input  logic                 mul_nx,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_result,
    output logic [3:0]           resp_flags,
    output logic                 busy,
    output logic [4*NREQ-1:0]    sticky_flags,
    input  logic [NREQ-1:0]      flag_clr
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gid;
    logic               found;
    logic               hs;
    logic [IDW:0]       sum;
    logic [IDW-1:0]     idx;

    logic               iss_v;
    logic [IDW-1:0]     iss_id;
    logic [LATENCY-1:0] tag_v;
    logic [IDW-1:0]     tag_id [LATENCY];

    logic               out_v;

    // Round-robin search: first valid requester at or after ptr, wrapping mod NREQ.
    always_comb begin
        found = 1'b0;
        gid   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gid   = idx;
            end
        end
    end

    // Grant is suppressed during reset so nothing can be issued into a pipe being flushed.
    always_comb begin
        req_ready = '0;
        if (found && !rst) begin
            req_ready[gid] = 1'b1;
        end
    end

    assign hs = found & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            iss_v  <= 1'b0;
            iss_id <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            mul_rm <= '0;
        end else begin
            iss_v <= hs;
            if (hs) begin
                ptr    <= (gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1;
                iss_id <= gid;
                mul_a  <= req_a[32*gid +: 32];
                mul_b  <= req_b[32*gid +: 32];
                mul_rm <= req_rm[3*gid +: 3];
            end else begin
                // Idle cycles present zero operands so the multiplier sees quiet inputs.
                iss_id <= '0;
                mul_a  <= '0;
                mul_b  <= '0;
                mul_rm <= '0;
            end
        end
    end

    // Tag pipe mirrors the multiplier depth; it shifts every cycle since nothing stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= iss_v;
            tag_id[0] <= iss_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // A tag reaching the end while rst is high belongs to a dropped operation.
    assign out_v = tag_v[LATENCY-1] & ~rst;

    always_comb begin
        resp_valid  = '0;
        resp_result = '0;
        resp_flags  = '0;
        if (out_v) begin
            for (int i = 0; i < NREQ; i++) begin
                resp_valid[i] = (tag_id[LATENCY-1] == IDW'(i));
            end
            resp_result = mul_result;
            resp_flags  = {mul_nv, mul_of, mul_uf, mul_nx};
        end
    end

    assign busy = iss_v | (|tag_v);

`ifdef FP_MUL_ARB_STICKY_EN
    logic [4*NREQ-1:0] sticky_q;

    // Clear and a same-cycle response together keep only the new flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (flag_clr[i] && resp_valid[i]) begin
                    sticky_q[4*i +: 4] <= resp_flags;
                end else if (flag_clr[i]) begin
                    sticky_q[4*i +: 4] <= 4'b0000;
                end else if (resp_valid[i]) begin
                    sticky_q[4*i +: 4] <= sticky_q[4*i +: 4] | resp_flags;
                end
            end
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_flag_clr;

    assign unused_flag_clr = ^flag_clr;
    assign sticky_flags    = '0;
`endif

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// tb/tb_fp32_mul_arbiter.sv - scoreboard bench for fp32_mul_arbiter with a stand-in pipelined multiplier
module tb_fp32_mul_arbiter;

    localparam int NREQ = 2;
    localparam int LAT  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [3*NREQ-1:0]   req_rm;
    logic [31:0]         mul_a, mul_b;
    logic [2:0]          mul_rm;
    logic [31:0]         mul_result;
    logic                mul_nv, mul_of, mul_uf, mul_nx;
    logic [NREQ-1:0]     resp_valid;
    logic [31:0]         resp_result;
    logic [3:0]          resp_flags;
    logic                busy;
    logic [4*NREQ-1:0]   sticky_flags;
    logic [NREQ-1:0]     flag_clr;

    fp32_mul_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
        .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm),
        .mul_result(mul_result),
        .mul_nv(mul_nv), .mul_of(mul_of), .mul_uf(mul_uf), .mul_nx(mul_nx),
        .resp_valid(resp_valid), .resp_result(resp_result), .resp_flags(resp_flags),
        .busy(busy), .sticky_flags(sticky_flags), .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: known IEEE products for the directed vectors, a hash otherwise.
    function automatic logic [35:0] mul_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        logic [31:0] r;
        logic [3:0]  f;
        if (a == 32'h41200000 && b == 32'h41200000)      begin r = 32'h42C80000; f = 4'b0000; end
        else if (a == 32'h40000000 && b == 32'h40400000) begin r = 32'h40C00000; f = 4'b0000; end
        else if (a == 32'h3F800000 && b == 32'hC0000000) begin r = 32'hC0000000; f = 4'b0000; end
        else if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) begin r = 32'h7F800000; f = 4'b0101; end
        else if (a == 32'h7F800000 && b == 32'h00000000) begin r = 32'h7FC00000; f = 4'b1000; end
        else if (a == 32'h3F800001 && b == 32'h3F800001) begin r = 32'h3F800002; f = 4'b0001; end
        else begin
            r = (a * 32'd2654435761) ^ {b[15:0], b[31:16]} ^ {29'd0, rm};
            f = a[3:0] ^ b[7:4] ^ {1'b0, rm};
        end
        return {f, r};
    endfunction

    logic [35:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= mul_model(mul_a, mul_b, mul_rm);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign {mul_nv, mul_of, mul_uf, mul_nx, mul_result} = mpipe[LAT-1];

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  fl;
        int          hs;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          m_ptr = 0;
    bit          prev_hs = 0;
    logic [31:0] prev_a, prev_b;
    logic [2:0]  prev_rm;
    logic [3:0]  sm [NREQ];
    bit          fair_win = 0;
    int          gcnt [NREQ];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard: every cycle, compare DUT against the reference model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            logic [NREQ-1:0] exp_ready;
            logic [NREQ-1:0] exp_rv;
            int              g;
            int              rid;
            logic [3:0]      rfl;
            exp_ready = '0;
            g = -1;
            if (!rst) begin
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[j]) g = j;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("busy", 64'(busy), 64'(q.size() > 0 && q[0].hs < cyc));
            if (prev_hs) begin
                chk("mul_a", 64'(mul_a), 64'(prev_a));
                chk("mul_b", 64'(mul_b), 64'(prev_b));
                chk("mul_rm", 64'(mul_rm), 64'(prev_rm));
            end else begin
                chk("mul_a_idle", 64'(mul_a), 64'd0);
                chk("mul_b_idle", 64'(mul_b), 64'd0);
                chk("mul_rm_idle", 64'(mul_rm), 64'd0);
            end
            chk("sticky_flags", 64'(sticky_flags), 64'({sm[1], sm[0]}));
            rid = -1;
            rfl = '0;
            if (!rst && q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                exp_rv = '0;
                exp_rv[e.id] = 1'b1;
                rid = e.id;
                rfl = e.fl;
                chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
                chk("resp_result", 64'(resp_result), 64'(e.res));
                chk("resp_flags", 64'(resp_flags), 64'(e.fl));
            end else begin
                chk("resp_valid_idle", 64'(resp_valid), 64'd0);
                chk("resp_result_idle", 64'(resp_result), 64'd0);
                chk("resp_flags_idle", 64'(resp_flags), 64'd0);
            end
`ifdef FP_MUL_ARB_STICKY_EN
            for (int i = 0; i < NREQ; i++) begin
                if (flag_clr[i] && rid == i) sm[i] = rfl;
                else if (flag_clr[i])        sm[i] = 4'b0000;
                else if (rid == i)           sm[i] = sm[i] | rfl;
            end
`endif
            if (g >= 0) begin
                exp_t e;
                logic [35:0] m;
                prev_a  = req_a[32*g +: 32];
                prev_b  = req_b[32*g +: 32];
                prev_rm = req_rm[3*g +: 3];
                m = mul_model(prev_a, prev_b, prev_rm);
                e.id = g; e.res = m[31:0]; e.fl = m[35:32]; e.hs = cyc; e.due = cyc + LAT + 1;
                q.push_back(e);
                m_ptr = (g + 1) % NREQ;
                prev_hs = 1;
                if (fair_win) gcnt[g]++;
            end else begin
                prev_hs = 0;
            end
            if (rst) begin
                q.delete();
                m_ptr = 0;
                prev_hs = 0;
                for (int i = 0; i < NREQ; i++) sm[i] = 4'b0000;
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        req_valid[i] = 1'b1;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_rm[3*i +: 3] = rm;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sole requester is granted immediately, so one cycle of valid is one op.
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        set_req(i, a, b, rm);
        step(1);
        req_valid[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin sm[i] = 4'b0000; gcnt[i] = 0; end
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_rm = '0; flag_clr = '0;
        step(3);
        rst = 1'b0;

        step(10);                                            // idle

        issue(0, 32'h41200000, 32'h41200000, 3'd0);          // single op
        step(6);

        rst = 1'b1; step(1); rst = 1'b0;                     // contention after reset
        set_req(0, 32'h40000000, 32'h40400000, 3'd0);
        set_req(1, 32'h3F800000, 32'hC0000000, 3'd0);
        step(1);
        req_valid[0] = 1'b0;
        step(1);
        req_valid[1] = 1'b0;
        step(6);

        fair_win = 1;                                        // fairness
        for (int c = 0; c < 8; c++) begin
            set_req(0, $urandom, $urandom, 3'($urandom_range(0, 4)));
            set_req(1, $urandom, $urandom, 3'($urandom_range(0, 4)));
            step(1);
        end
        fair_win = 0;
        req_valid = '0;
        chk("fair_grants_req0", 64'(gcnt[0]), 64'd4);
        chk("fair_grants_req1", 64'(gcnt[1]), 64'd4);
        step(6);

        flag_clr = 2'b11; step(1); flag_clr = '0;            // exceptions
        issue(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0);
        issue(0, 32'h7F800000, 32'h00000000, 3'd0);
        step(6);
`ifdef FP_MUL_ARB_STICKY_EN
        chk("sticky_exc", 64'(sticky_flags), 64'({4'b0101, 4'b1000}));
`else
        chk("sticky_off", 64'(sticky_flags), 64'd0);
`endif
        issue(1, 32'h3F800001, 32'h3F800001, 3'd0);          // clear in response cycle
        step(3);
        flag_clr = 2'b10; step(1); flag_clr = '0;
`ifdef FP_MUL_ARB_STICKY_EN
        chk("sticky_clr_same_cycle", 64'(sticky_flags), 64'({4'b0001, 4'b1000}));
`else
        chk("sticky_off2", 64'(sticky_flags), 64'd0);
`endif
        step(4);

        set_req(0, $urandom, $urandom, 3'd1); step(1);       // reset mid-flight
        set_req(0, $urandom, $urandom, 3'd2); step(1);
        set_req(0, $urandom, $urandom, 3'd3); rst = 1'b1; step(1);
        rst = 1'b0; req_valid = '0;
        chk("busy_after_rst", 64'(busy), 64'd0);
        step(6);
        issue(1, 32'h41200000, 32'h41200000, 3'd0);          // ptr=0 but sole requester
        step(6);

        for (int c = 0; c < 300; c++) begin                  // random traffic
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                req_a[32*i +: 32] = $urandom;
                req_b[32*i +: 32] = $urandom;
                req_rm[3*i +: 3] = 3'($urandom_range(0, 4));
            end
            flag_clr = NREQ'($urandom_range(0, 7) == 0 ? $urandom : 0);
            step(1);
        end
        req_valid = '0; flag_clr = '0;
        step(LAT + 4);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
